// File: rtl/huffman_gen.sv
// huffman_gen: parametrised streaming Huffman coder.
//
// It counts symbol occurrences from a streaming input and builds a Huffman
// tree by merging the two lightest active nodes once per cycle. It then
// publishes right-aligned codes and LSB-aligned masks for every symbol on
// flat buses. Symbols with a zero count take no part in the tree.
//
// Parameters:
//   NSYM  number of symbols (2..16); valid symbol values are 1..NSYM
//   CW    width of each count (counts saturate at 2^CW-1)
//   HW    width of each code/mask, i.e. the maximum code length
//
// Ports:
//   clk         single clock, rising edge
//   reset       synchronous active-high reset
//   gray_valid  gray_data is valid this cycle
//   gray_data   symbol index (only 1..NSYM are counted)
//   CNT_valid   one-cycle pulse: cnt_bus is final
//   cnt_bus     count of symbol i at [(i-1)*CW +: CW]
//   code_valid  one-cycle pulse: hc_bus/m_bus are final
//   hc_bus      code of symbol i at [(i-1)*HW +: HW], right-aligned
//   m_bus       mask of symbol i; ones mark the valid code bits
//   err         sticky error flag, cleared when a new frame starts
//
// Build option:
//   HUFF_ERR_EN  when defined, err flags out-of-range symbols, count
//                saturation and code-length overflow. Otherwise err is 0.
module huffman_gen #(
  parameter int NSYM = 6,
  parameter int CW   = 8,
  parameter int HW   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 gray_valid,
  input  logic [7:0]           gray_data,
  output logic                 CNT_valid,
  output logic [NSYM*CW-1:0]   cnt_bus,
  output logic                 code_valid,
  output logic [NSYM*HW-1:0]   hc_bus,
  output logic [NSYM*HW-1:0]   m_bus,
  output logic                 err
);

  localparam int IW = $clog2(NSYM);
  localparam int KW = $clog2(NSYM + 1);
  localparam int WW = CW + $clog2(NSYM);
  localparam int LW = $clog2(HW + 1);

  typedef enum logic [2:0] {IDLE, COUNT, CNTV, MERGE, DONE} state_t;

  state_t          state;
  logic [WW-1:0]   weight  [NSYM];
  logic [NSYM-1:0] members [NSYM];
  logic [NSYM-1:0] active;
  logic [LW-1:0]   len     [NSYM];

  logic [NSYM-1:0] hit;
  logic [NSYM-1:0] nonzero;
  logic [KW-1:0]   k_load;
  logic [KW-1:0]   k_active;
  logic [IW-1:0]   min1;
  logic [IW-1:0]   min2;
  logic [IW-1:0]   lo;
  logic [IW-1:0]   hi;
  logic            found1;
  logic            found2;
  logic [NSYM-1:0] merged;

  // Symbol decode and per-slot population counts.
  always_comb begin
    k_load   = '0;
    k_active = '0;
    for (int i = 0; i < NSYM; i++) begin
      hit[i]     = (gray_data == 8'(i + 1));
      nonzero[i] = |cnt_bus[i*CW +: CW];
      k_load     = k_load + KW'(nonzero[i]);
      k_active   = k_active + KW'(active[i]);
    end
  end

  // Two-minimum search over active slots. The scan runs in ascending slot
  // order and uses strict compares, so on a tie the lower slot wins.
  always_comb begin
    min1   = '0;
    min2   = '0;
    found1 = 1'b0;
    found2 = 1'b0;
    for (int i = 0; i < NSYM; i++) begin
      if (active[i]) begin
        if (!found1 || weight[i] < weight[min1]) begin
          min2   = min1;
          found2 = found1;
          min1   = IW'(i);
          found1 = 1'b1;
        end else if (!found2 || weight[i] < weight[min2]) begin
          min2   = IW'(i);
          found2 = 1'b1;
        end
      end
    end
    lo     = (min1 < min2) ? min1 : min2;
    hi     = (min1 < min2) ? min2 : min1;
    merged = members[min1] | members[min2];
  end

  // Main FSM. CNT_valid and code_valid are registered one-cycle pulses.
  // Codes grow from the LSB up: each merge writes one bit at the current
  // length of every member symbol.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      CNT_valid  <= 1'b0;
      code_valid <= 1'b0;
      cnt_bus    <= '0;
      hc_bus     <= '0;
      m_bus      <= '0;
      active     <= '0;
      for (int i = 0; i < NSYM; i++) begin
        weight[i]  <= '0;
        members[i] <= '0;
        len[i]     <= '0;
      end
    end else begin
      CNT_valid  <= 1'b0;
      code_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (gray_valid) begin
            // A new frame clears the previous results and counts its first symbol.
            for (int i = 0; i < NSYM; i++) begin
              cnt_bus[i*CW +: CW] <= hit[i] ? CW'(1) : '0;
              len[i]              <= '0;
            end
            hc_bus <= '0;
            m_bus  <= '0;
            state  <= COUNT;
          end
        end
        COUNT: begin
          if (gray_valid) begin
            for (int i = 0; i < NSYM; i++) begin
              if (hit[i] && (cnt_bus[i*CW +: CW] != '1)) begin
                cnt_bus[i*CW +: CW] <= cnt_bus[i*CW +: CW] + CW'(1);
              end
            end
          end else begin
            CNT_valid <= 1'b1;
            state     <= CNTV;
          end
        end
        CNTV: begin
          for (int i = 0; i < NSYM; i++) begin
            weight[i]  <= WW'(cnt_bus[i*CW +: CW]);
            members[i] <= NSYM'(1) << i;
          end
          active <= nonzero;
          if (k_load <= KW'(1)) begin
            // No tree to build: a lone symbol gets the 1-bit code 0.
            for (int i = 0; i < NSYM; i++) begin
              if (nonzero[i]) begin
                m_bus[i*HW] <= 1'b1;
              end
            end
            code_valid <= 1'b1;
            state      <= DONE;
          end else begin
            state <= MERGE;
          end
        end
        MERGE: begin
          for (int s = 0; s < NSYM; s++) begin
            if (merged[s] && (len[s] < LW'(HW))) begin
              hc_bus[s*HW + int'(len[s])] <= members[min1][s];
              m_bus[s*HW + int'(len[s])]  <= 1'b1;
              len[s]                      <= len[s] + LW'(1);
            end
          end
          weight[lo]  <= weight[min1] + weight[min2];
          members[lo] <= merged;
          active[hi]  <= 1'b0;
          if (k_active <= KW'(2)) begin
            code_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef HUFF_ERR_EN
  logic            sym_ok;
  logic [NSYM-1:0] saturated;
  logic            err_event;

  // Error sources: a symbol outside 1..NSYM, an increment of a count that
  // is already at its maximum, or a merge into a code that is already HW
  // bits long.
  always_comb begin
    sym_ok    = (gray_data != 8'd0) && (gray_data <= 8'(NSYM));
    err_event = 1'b0;
    for (int i = 0; i < NSYM; i++) begin
      saturated[i] = &cnt_bus[i*CW +: CW];
    end
    if ((state == IDLE || state == COUNT) && gray_valid && !sym_ok) begin
      err_event = 1'b1;
    end
    if ((state == COUNT) && gray_valid && |(hit & saturated)) begin
      err_event = 1'b1;
    end
    if (state == MERGE) begin
      for (int s = 0; s < NSYM; s++) begin
        if (merged[s] && (len[s] == LW'(HW))) begin
          err_event = 1'b1;
        end
      end
    end
  end

  // Sticky flag; the first symbol of a frame restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (state == IDLE && gray_valid) begin
      err <= err_event;
    end else if (err_event) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_huffman_gen.sv
// tb_huffman_gen: self-checking bench for huffman_gen.
//
// The bench drives frames from a vector table and, for each frame, pushes
// the expected counts and codes into scoreboard queues. A negedge monitor
// pops and compares them whenever CNT_valid or code_valid pulses. A second
// instance with HW=2 sees the same stimulus to exercise code-length overflow.
module tb_huffman_gen;

  localparam int NSYM = 6;
  localparam int CW   = 8;
  localparam int HW   = 8;
  localparam int HW2  = 2;

`ifdef HUFF_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                grayValid;
  logic [7:0]          grayData;
  logic                cntValid;
  logic [NSYM*CW-1:0]  cntBus;
  logic                codeValid;
  logic [NSYM*HW-1:0]  hcBus;
  logic [NSYM*HW-1:0]  mBus;
  logic                err;
  logic                cntValid2;
  logic [NSYM*CW-1:0]  cntBus2;
  logic                codeValid2;
  logic [NSYM*HW2-1:0] hcBus2;
  logic [NSYM*HW2-1:0] mBus2;
  logic                err2;

  typedef struct {
    int          n;
    logic [63:0] symHex;
    logic [47:0] cnt;
    logic [47:0] hc;
    logic [47:0] m;
    logic        errIfEn;
    int          lat;
  } vec_t;

  typedef struct {
    logic [47:0] hc;
    logic [47:0] m;
    logic        err;
    int          lat;
  } codeExp_t;

  logic [47:0] cntQ[$];
  codeExp_t    codeQ[$];
  vec_t        vecs[6];
  logic [47:0] eCnt;
  codeExp_t    eCode;

  int tests    = 0;
  int fails    = 0;
  int cycle    = 0;
  int cntCycle = 0;
  int cntSeen  = 0;
  int codeSeen = 0;

  huffman_gen #(.NSYM(NSYM), .CW(CW), .HW(HW)) dut (
    .clk        (clk),
    .reset      (reset),
    .gray_valid (grayValid),
    .gray_data  (grayData),
    .CNT_valid  (cntValid),
    .cnt_bus    (cntBus),
    .code_valid (codeValid),
    .hc_bus     (hcBus),
    .m_bus      (mBus),
    .err        (err)
  );

  huffman_gen #(.NSYM(NSYM), .CW(CW), .HW(HW2)) dut2 (
    .clk        (clk),
    .reset      (reset),
    .gray_valid (grayValid),
    .gray_data  (grayData),
    .CNT_valid  (cntValid2),
    .cnt_bus    (cntBus2),
    .code_valid (codeValid2),
    .hc_bus     (hcBus2),
    .m_bus      (mBus2),
    .err        (err2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares DUT results against the queued expectations.
  always @(negedge clk) begin
    if (cntValid) begin
      cntCycle = cycle;
      cntSeen++;
      checkOutput("CNT_valid expected", 64'(cntQ.size() != 0), 64'd1);
      if (cntQ.size() != 0) begin
        eCnt = cntQ.pop_front();
        checkOutput("cnt_bus", 64'(cntBus), 64'(eCnt));
      end
    end
    if (codeValid) begin
      codeSeen++;
      checkOutput("code_valid expected", 64'(codeQ.size() != 0), 64'd1);
      if (codeQ.size() != 0) begin
        eCode = codeQ.pop_front();
        checkOutput("hc_bus", 64'(hcBus), 64'(eCode.hc));
        checkOutput("m_bus", 64'(mBus), 64'(eCode.m));
        checkOutput("err", 64'(err), 64'(eCode.err));
        checkOutput("code latency", 64'(cycle - cntCycle), 64'(eCode.lat));
      end
      checkOutput("HW=2 code_valid timing", 64'(codeValid2), 64'd1);
    end
  end

  task automatic pushExpect(input logic [47:0] cnt, input logic [47:0] hc, input logic [47:0] m,
                            input logic errIfEn, input int lat, input bit withCode);
    codeExp_t e;
    cntQ.push_back(cnt);
    if (withCode) begin
      e.hc  = hc;
      e.m   = m;
      e.err = errIfEn & ERR_EN;
      e.lat = lat;
      codeQ.push_back(e);
    end
  endtask

  // Symbols are hex digits, first symbol in the most significant digit.
  task automatic applyStimulus(input int n, input logic [63:0] symHex);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      grayValid = 1'b1;
      grayData  = {4'd0, symHex[4*(n-1-k) +: 4]};
    end
    @(negedge clk);
    grayValid = 1'b0;
    grayData  = 8'd0;
  endtask

  task automatic waitCode();
    int start = codeSeen;
    int k = 0;
    while (codeSeen == start && k < 60) begin
      @(negedge clk);
      k++;
    end
    checkOutput("code_valid arrived", 64'(codeSeen != start), 64'd1);
  endtask

  task automatic runVector(input vec_t v);
    pushExpect(v.cnt, v.hc, v.m, v.errIfEn, v.lat, 1'b1);
    applyStimulus(v.n, v.symHex);
    waitCode();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int start;
    int k;

    vecs[0] = '{8,  64'h11112234,     48'h000001010204, 48'h000000010101, 48'h000007070301, 1'b0, 4};
    vecs[1] = '{3,  64'h222,          48'h000000000300, 48'h000000000000, 48'h000000000100, 1'b0, 1};
    vecs[2] = '{6,  64'h019271,       48'h000000000102, 48'h000000000100, 48'h000000000101, 1'b1, 2};
    vecs[3] = '{12, 64'h122333444456, 48'h010104030201, 48'h050800010309, 48'h070F0303030F, 1'b0, 6};
    vecs[4] = '{2,  64'h09,           48'h000000000000, 48'h000000000000, 48'h000000000000, 1'b1, 1};
    vecs[5] = '{1,  64'h6,            48'h010000000000, 48'h000000000000, 48'h010000000000, 1'b0, 1};

    reset     = 1'b1;
    grayValid = 1'b0;
    grayData  = 8'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset cnt_bus", 64'(cntBus), 64'd0);
    checkOutput("reset hc_bus", 64'(hcBus), 64'd0);
    checkOutput("reset m_bus", 64'(mBus), 64'd0);
    checkOutput("reset CNT_valid", 64'(cntValid), 64'd0);
    checkOutput("reset code_valid", 64'(codeValid), 64'd0);
    checkOutput("reset err", 64'(err), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      runVector(vecs[i]);
      if (i == 0) begin
        checkOutput("HW=2 hc_bus", 64'(hcBus2), 64'h015);
        checkOutput("HW=2 m_bus", 64'(mBus2), 64'h0FD);
        checkOutput("HW=2 err", 64'(err2), 64'(ERR_EN));
      end
    end

    // 300 consecutive symbol-1 inputs: count climbs one per cycle and
    // saturates at 255.
    pushExpect(48'h0000000000FF, 48'h0, 48'h000000000001, 1'b1, 1, 1'b1);
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      if (j == 1 || j == 2 || j == 255 || j == 256) begin
        checkOutput("cnt1 running", 64'(cntBus[7:0]), 64'((j > 255) ? 255 : j));
      end
      grayValid = 1'b1;
      grayData  = 8'd1;
    end
    @(negedge clk);
    grayValid = 1'b0;
    grayData  = 8'd0;
    waitCode();
    repeat (2) @(negedge clk);

    // Reset while merging: the frame is abandoned, so no code_valid may follow.
    pushExpect(vecs[0].cnt, 48'h0, 48'h0, 1'b0, 0, 1'b0);
    start = cntSeen;
    applyStimulus(vecs[0].n, vecs[0].symHex);
    k = 0;
    while (cntSeen == start && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("CNT_valid before reset", 64'(cntSeen != start), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("merge-reset cnt_bus", 64'(cntBus), 64'd0);
    checkOutput("merge-reset hc_bus", 64'(hcBus), 64'd0);
    checkOutput("merge-reset m_bus", 64'(mBus), 64'd0);
    checkOutput("merge-reset code_valid", 64'(codeValid), 64'd0);
    checkOutput("merge-reset err", 64'(err), 64'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    runVector(vecs[3]);
    runVector(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/huffman_gen.md
# huffman_gen

Parametrised Huffman coder, successor to the fixed six-symbol coder in the CF design. It counts symbol occurrences from a streaming input, builds the Huffman tree by iterative two-minimum merging, and emits per-symbol right-aligned codes and masks on flat buses. It supports any symbol count `NSYM` and excludes zero-count symbols from the tree. It sits between the gray-level data source and downstream packers and replaces the `CNTcounter`/`PE`/`MINmem`/`encoder` chain with one self-contained block.

## Interface
- `NSYM`, default 6: number of symbols, 2..16; valid symbols are 1..`NSYM`.
- `CW`, default 8: width of each count output; counts saturate at 2^`CW`-1.
- `HW`, default 8: width of each code and mask; maximum code length.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high; clears all state and outputs.
- `gray_valid`  in  1: `gray_data` is valid this cycle.
- `gray_data`  in  8: symbol index; only 1..`NSYM` are counted.
- `CNT_valid`  out  1: one-cycle pulse; `cnt_bus` is final.
- `cnt_bus`  out  `NSYM*CW`: count of symbol i in slice [(i-1)*CW +: CW].
- `code_valid`  out  1: one-cycle pulse; `hc_bus` and `m_bus` are final.
- `hc_bus`  out  `NSYM*HW`: code of symbol i, right-aligned, same slicing.
- `m_bus`  out  `NSYM*HW`: mask of symbol i; ones mark the valid code bits (LSB-aligned).
- `err`  out  1: sticky error flag (see Configuration); cleared on a new frame.

## Operation
- The FSM has states IDLE, COUNT, CNTV, MERGE, DONE.
- **IDLE to COUNT** on `gray_valid`=1:
  - Clear counts, codes, masks and `err`.
  - Count the first symbol in the same edge.
- **COUNT:**
  - Each cycle with `gray_valid`=1, increment the matching count, saturating.
  - Out-of-range symbols (0 or >`NSYM`) are ignored.
  - `gray_valid`=0 moves to CNTV.
- **CNTV** (one cycle): `CNT_valid`=1.
  - Load node slot i with weight = count i (width `CW`+clog2(`NSYM`), no overflow) and member set = {i}.
  - A slot is active only if its count is non-zero. K = number of active slots.
- **MERGE** (one merge per cycle while more than one slot is active):
  - min1 is the smallest active weight and min2 the next smallest.
  - Ties go to the lower slot index as the smaller.
  - Every symbol in min1 gets bit 1 and every symbol in min2 gets bit 0, written at position len(sym). Set the mask bit and increment len.
  - The merged node goes into the lower-indexed of the two slots, with weight = sum and member set = union. The other slot is deactivated.
- **Exit to DONE** when at most one slot is active.
  - K=1: that symbol gets code 0 with mask 1.
  - K=0: all masks are 0.
- **DONE** (one cycle): `code_valid`=1, then go to IDLE.
- Outputs hold their values in IDLE until the next frame starts.
- `gray_valid` outside COUNT and IDLE is ignored.

## Timing
- Reset value of all outputs is 0, and the state is IDLE.
- `reset` in any state takes effect at the next edge and abandons the frame.
- Counts are visible one cycle after the accepted symbol.
- Let `CNT_valid` be high in cycle T.
  - K≥2: merges happen in cycles T+1..T+K-1 and `code_valid` is high in T+K.
  - K≤1: `code_valid` is high in T+1.
- Worst-case frame overhead is `NSYM`+1 cycles after `gray_valid` falls.
- A `gray_valid` pulse of exactly one cycle is a valid frame of one symbol.

## Configuration
- Macro: `HUFF_ERR_EN`.
- **Defined:** `err` sets (sticky until the next frame) on any of:
  - an out-of-range symbol in COUNT;
  - count saturation;
  - a merge that would push any len beyond `HW`.

  On a len overflow, the bits beyond `HW` are dropped, the mask stays at `HW` ones, and the merge still completes.
- **Undefined:** `err` is tied to 0. The same conditions are silently ignored and the port remains.

## Test plan
- NSYM=6: stream 1,1,1,1,2,2,3,4, then drop `gray_valid` → `CNT_valid` pulse with cnt 4,2,1,1,0,0. Four cycles later `code_valid` with HC1..4 = 0x01,0x01,0x01,0x00, M1..4 = 0x01,0x03,0x07,0x07, M5 = M6 = 0.
- Only symbol 2 three times → cnt2 = 3; `code_valid` at T+1 with HC2 = 0, M2 = 0x01, all other masks 0.
- 300 consecutive symbol-1 inputs, CW=8 → cnt1 = 255. `err`=1 only with `HUFF_ERR_EN`.
- Symbols 0, 9 and 7 interleaved with valid 1/2 (NSYM=6) → only symbols 1/2 counted. `err` follows the macro.
- First vector with HW=2 → `err`=1 (`HUFF_ERR_EN`), M3 = M4 = 0x03. `code_valid` timing is unchanged.
- `reset` asserted during MERGE → next cycle all outputs 0 and state IDLE. The next frame produces correct codes.
